// File: rtl/tqvp_bus_pkg.sv
// Shared encodings for the TinyQV peripheral bus initiator: transfer sizes and FSM states.
package tqvp_bus_pkg;

  // Transfer size as driven on data_write_n / data_read_n; 11 means no access.
  localparam logic [1:0] Size8b      = 2'b00;
  localparam logic [1:0] Size16b     = 2'b01;
  localparam logic [1:0] Size32b     = 2'b10;
  localparam logic [1:0] SizeIllegal = 2'b11;
  localparam logic [1:0] SizeIdle    = 2'b11;

  // Initiator FSM states.
  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StWrite = 2'b01;
  localparam logic [1:0] StRead  = 2'b10;
  localparam logic [1:0] StResp  = 2'b11;

  // Byte-lane mask used to zero-extend read data to the transfer size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      Size8b:  return 32'h0000_00ff;
      Size16b: return 32'h0000_ffff;
      Size32b: return 32'hffff_ffff;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_edge_capture.sv
// Rising-edge detector with a sticky pending flag; a new edge wins over a clear.
module tqvp_edge_capture (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clear,
  output logic pending
);

  logic irq_prev_q;
  logic pending_q, pending_d;

  // Next pending value: set on 0->1, else clear on request, else hold.
  always_comb begin
    pending_d = pending_q;
    if (irq && !irq_prev_q) begin
      pending_d = 1'b1;
    end else if (clear) begin
      pending_d = 1'b0;
    end
  end

  // History and pending registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/tqvp_bus_initiator.sv
// Command/response front end that runs single bus cycles against a TinyQV peripheral.
module tqvp_bus_initiator
  import tqvp_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        bus_irq,
  input  logic        irq_clear,
  output logic        irq_pending,
  output logic [7:0]  err_count
);

  localparam logic [7:0] LastReadCycle = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Next-state, command latching and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          size_d  = cmd_size;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (cmd_size == SizeIllegal) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (cmd_write) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StWrite: begin
        state_d = StResp;
      end
      StRead: begin
        if (bus_ready) begin
          rdata_d = bus_rdata & size_mask(size_q);
          state_d = StResp;
        end else if (cnt_q == LastReadCycle) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Count each error response once, on the transition into RESP.
    if (state_q != StResp && state_d == StResp && err_d && err_cnt_q != 8'hff) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SizeIdle;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Strobes decoded from state only, so read and write can never overlap.
  always_comb begin
    cmd_ready   = (state_q == StIdle);
    rsp_valid   = (state_q == StResp);
    bus_write_n = (state_q == StWrite) ? size_q : SizeIdle;
    bus_read_n  = (state_q == StRead) ? size_q : SizeIdle;
  end

  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign err_count   = err_cnt_q;

  tqvp_edge_capture u_irq_capture (
    .clk     (clk),
    .rst     (rst),
    .irq     (bus_irq),
    .clear   (irq_clear),
    .pending (irq_pending)
  );

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator with TIMEOUT=4: vector table plus corner sequences.
module tb_tqvp_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata, bus_rdata;
  logic [1:0]  bus_write_n, bus_read_n;
  logic        bus_ready, bus_irq, irq_clear, irq_pending;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;

  tqvp_bus_initiator #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_size    (cmd_size),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_write_n (bus_write_n),
    .bus_read_n  (bus_read_n),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .bus_irq     (bus_irq),
    .irq_clear   (irq_clear),
    .irq_pending (irq_pending),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          delay;     // READ cycles before bus_ready; >= 4 means never
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_act;   // cycles with a strobe active
    int          exp_lat;   // cycles from N+1 until rsp_valid
    logic [1:0]  exp_n;     // strobe value seen while active
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int act = 0;
    int k = 0;
    logic both = 1'b0;
    logic [1:0] seen_n = 2'b11;
    logic [31:0] held;
    check($sformatf("v%0d_cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
    cmd_write = v.write;
    cmd_size  = v.size;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    bus_rdata = v.brdata;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    while (!rsp_valid && k < 20) begin
      if (bus_write_n != 2'b11 && bus_read_n != 2'b11) both = 1'b1;
      if (bus_write_n != 2'b11) begin act++; seen_n = bus_write_n; end
      if (bus_read_n != 2'b11) begin act++; seen_n = bus_read_n; end
      bus_ready = (bus_read_n != 2'b11) && (act - 1 == v.delay);
      step();
      bus_ready = 1'b0;
      k++;
    end
    if (v.exp_err) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    check($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
    check($sformatf("v%0d_latency", i), k, v.exp_lat);
    check($sformatf("v%0d_bus_cycles", i), act, v.exp_act);
    check($sformatf("v%0d_strobe", i), {30'd0, seen_n}, {30'd0, v.exp_n});
    check($sformatf("v%0d_exclusive", i), {31'd0, both}, 32'd0);
    check($sformatf("v%0d_rdata", i), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", i), {31'd0, rsp_err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_err_count", i), {24'd0, err_count}, exp_errs);
    check($sformatf("v%0d_bus_address", i), {26'd0, bus_address}, {26'd0, v.addr});
    check($sformatf("v%0d_bus_wdata", i), bus_wdata, v.wdata);
    held = rsp_rdata;
    step();
    step();
    check($sformatf("v%0d_hold_valid", i), {31'd0, rsp_valid}, 32'd1);
    check($sformatf("v%0d_hold_rdata", i), rsp_rdata, held);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check($sformatf("v%0d_back_idle", i), {30'd0, rsp_valid, cmd_ready}, 32'd1);
    check($sformatf("v%0d_addr_held", i), {26'd0, bus_address}, {26'd0, v.addr});
  endtask

  initial begin
    logic strobe_seen;
    vecs[0] = '{1'b1, 2'b10, 6'h18, 32'h0000_0355, 32'h0, 99, 32'h0, 1'b0, 1, 1, 2'b10};
    vecs[1] = '{1'b0, 2'b00, 6'h24, 32'h0, 32'hdead_beef, 0, 32'h0000_00ef, 1'b0, 1, 1, 2'b00};
    vecs[2] = '{1'b0, 2'b01, 6'h24, 32'h0, 32'hdead_beef, 0, 32'h0000_beef, 1'b0, 1, 1, 2'b01};
    vecs[3] = '{1'b0, 2'b10, 6'h3f, 32'h1, 32'h1234_5678, 2, 32'h1234_5678, 1'b0, 3, 3, 2'b10};
    vecs[4] = '{1'b0, 2'b00, 6'h05, 32'h2, 32'ha5a5_a5c3, 3, 32'h0000_00c3, 1'b0, 4, 4, 2'b00};
    vecs[5] = '{1'b0, 2'b10, 6'h11, 32'h3, 32'hffff_ffff, 99, 32'h0, 1'b1, 4, 4, 2'b10};
    vecs[6] = '{1'b1, 2'b11, 6'h01, 32'h4, 32'hffff_ffff, 0, 32'h0, 1'b1, 0, 0, 2'b11};
    vecs[7] = '{1'b1, 2'b00, 6'h2a, 32'hcafe_f00d, 32'h0, 99, 32'h0, 1'b0, 1, 1, 2'b00};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; bus_rdata = '0; bus_ready = 1'b0; bus_irq = 1'b0; irq_clear = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_write_n", {30'd0, bus_write_n}, 32'd3);
    check("rst_read_n", {30'd0, bus_read_n}, 32'd3);
    check("rst_address", {26'd0, bus_address}, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);

    // bus_ready outside READ must not disturb an idle initiator.
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    check("idle_ready_ignored", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Edge and clear together: edge wins; held level after clear does not re-set.
    bus_irq = 1'b1; irq_clear = 1'b1;
    step();
    check("irq_set_wins", {31'd0, irq_pending}, 32'd1);
    irq_clear = 1'b0;
    step();
    check("irq_sticky", {31'd0, irq_pending}, 32'd1);
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    check("irq_cleared", {31'd0, irq_pending}, 32'd0);
    step();
    check("irq_level_no_set", {31'd0, irq_pending}, 32'd0);
    bus_irq = 1'b0;
    step();
    bus_irq = 1'b1;
    step();
    check("irq_second_edge", {31'd0, irq_pending}, 32'd1);

    // 300 illegal-size commands, two cycles each, with no bus activity.
    strobe_seen = 1'b0;
    cmd_size = 2'b11; cmd_write = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (bus_write_n != 2'b11 || bus_read_n != 2'b11) strobe_seen = 1'b1;
      step();
      if (bus_write_n != 2'b11 || bus_read_n != 2'b11) strobe_seen = 1'b1;
      exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
      if (n == 200) check("sat_mid_count", {24'd0, err_count}, exp_errs);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("sat_count", {24'd0, err_count}, 32'd255);
    check("sat_no_bus", {31'd0, strobe_seen}, 32'd0);

    // Reset in READ with rsp_ready held high: abort, no response.
    cmd_size = 2'b10; cmd_addr = 6'h07; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    check("abort_in_read", {30'd0, bus_read_n}, 32'd2);
    step();
    rst = 1'b1;
    step();
    check("abort_read_n", {30'd0, bus_read_n}, 32'd3);
    check("abort_no_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    step();
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    strobe_seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (rsp_valid) strobe_seen = 1'b1;
    end
    check("abort_no_rsp", {31'd0, strobe_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_bus_initiator.md
TQVP_BUS_INITIATOR -- requirements
Module: tqvp_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, range 1..255: maximum READ-state cycles spent waiting for bus_ready.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_size  in  2  00=8b, 01=16b, 10=32b, 11=illegal
- cmd_addr  in  6  peripheral address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data, zero-extended to size
- rsp_err  out  1  illegal size or timeout
- bus_address  out  6  to peripheral address
- bus_wdata  out  32  to peripheral data_in
- bus_write_n  out  2  to peripheral data_write_n
- bus_read_n  out  2  to peripheral data_read_n
- bus_rdata  in  32  from peripheral data_out
- bus_ready  in  1  from peripheral data_ready
- bus_irq  in  1  from peripheral user_interrupt
- irq_clear  in  1  clears irq_pending
- irq_pending  out  1  sticky rising-edge capture of bus_irq
- err_count  out  8  saturating count of error responses
REQ-003 Clocking SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, WRITE, READ, RESP; cmd_ready high only in IDLE.
REQ-005 On accept in IDLE, SHALL latch addr/wdata/size/write into bus_address/bus_wdata/size register; size 11 -> RESP with rsp_err=1, rsp_rdata=0, no bus cycle.
REQ-006 Write accepted cycle N: SHALL drive bus_write_n=size during cycle N+1 only (WRITE), rsp_valid high from N+2, rsp_err=0, rsp_rdata=0.
REQ-007 Read accepted cycle N: SHALL drive bus_read_n=size from N+1 every READ cycle until bus_ready sampled high; bus_ready ignored outside READ.
REQ-008 On bus_ready in READ SHALL capture bus_rdata masked: 8b -> [7:0], 16b -> [15:0], 32b -> all; upper bits zero; go RESP next cycle (ready at N+1 -> rsp_valid at N+2).
REQ-009 READ cycle counter SHALL reset to 0 on READ entry; if bus_ready is not seen within TIMEOUT READ cycles, next state RESP, rsp_err=1, rsp_rdata=0; bus_ready in cycle TIMEOUT still counts as success.
REQ-010 bus_write_n and bus_read_n SHALL be 11 in all other states; never both active in one cycle.
REQ-011 bus_address/bus_wdata SHALL hold last latched values between commands.
REQ-012 rsp_valid, rsp_rdata, rsp_err SHALL remain stable in RESP until rsp_ready; on rsp_ready return to IDLE (next command acceptable one cycle later, no bypass).
REQ-013 err_count SHALL increment once per error response on entering RESP, saturating at 255.
REQ-014 irq_pending SHALL set on bus_irq 0->1 (registered previous value); irq_clear clears; simultaneous edge and clear -> set wins.

Reset
REQ-015 rst SHALL force: state IDLE, cmd_ready 1 after reset release, rsp_valid 0, rsp_rdata 0, rsp_err 0, bus_write_n 11, bus_read_n 11, bus_address 0, bus_wdata 0, irq_pending 0, bus_irq history 0, err_count 0, counter 0.
REQ-016 rst mid-transaction SHALL abort immediately; no response produced for aborted command.

Structure
REQ-017 Shared package tqvp_bus_pkg SHALL hold size encodings (8b/16b/32b/illegal, idle 11) and FSM state enumeration.
REQ-018 One sub-module tqvp_edge_capture SHALL implement irq edge detect and sticky pending; all else in tqvp_bus_initiator.

Verification
REQ-019 Write cmd size 10 addr 0x18 wdata 0x00000355 -> one cycle bus_write_n=10, bus_address=0x18; rsp_valid at N+2, rsp_err=0.
REQ-020 Read size 00 addr 0x24, bus_ready=1 with bus_rdata 0xDEADBEEF -> rsp_rdata 0x000000EF at N+2; size 01 -> 0x0000BEEF.
REQ-021 Read with bus_ready held 0, TIMEOUT=4 -> bus_read_n active exactly 4 cycles, rsp_err=1, rsp_rdata 0, err_count 1.
REQ-022 cmd_size 11 -> no bus activity, rsp_err=1; 300 such commands -> err_count 255.
REQ-023 bus_irq rising edge same cycle as irq_clear -> irq_pending 1; later irq_clear alone -> 0.
REQ-024 rst asserted in READ with rsp_ready held 1 -> bus_read_n 11 next cycle, no rsp_valid, cmd_ready 1 after release.
